trajectory: RTL and testbench



---
 rtl/trajectory_pkg.sv | 19 +
 rtl/trajectory_if.sv | 29 ++
 rtl/trajectory_tick.sv | 39 +++
 rtl/trajectory.sv | 70 +++++++
 tb/tb_trajectory.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/trajectory_pkg.sv
// Shared constants and types for the trajectory position generator.
`timescale 1ns/1ps
package trajectory_pkg;

  // Direction encoding carried on the direction input.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Width of the cycle counter and of the threshold (speed divisor).
  localparam int COUNT_W = 64;

  // Default axis width; coordinate is DEFAULT_WIDTH+1 bits wide.
  localparam int DEFAULT_WIDTH = 8;

  typedef logic [COUNT_W-1:0]     count_t;
  // Coordinate vector for the default axis width (0..511).
  typedef logic [DEFAULT_WIDTH:0] coord_t;

endpackage

// File: rtl/trajectory_if.sv
// Control/position bundle between the collision logic (master) and one
// trajectory axis (slave).
`timescale 1ns/1ps
interface trajectory_if
  import trajectory_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic           active;      // 1 = motion enabled, 0 = freeze
  logic           direction;   // DIR_UP increments, DIR_DOWN decrements
  count_t         threshold;   // clock cycles per unit step
  logic [WIDTH:0] coordinate;  // registered position

  modport master (
    output active,
    output direction,
    output threshold,
    input  coordinate
  );

  modport slave (
    input  active,
    input  direction,
    input  threshold,
    output coordinate
  );

endinterface

// File: rtl/trajectory_tick.sv
// Rate divider: counts enabled cycles and raises a one-cycle step pulse
// every `threshold` edges (every edge for threshold 0 or 1).
`timescale 1ns/1ps
module trajectory_tick
  import trajectory_pkg::*;
(
  input  logic   clock,
  input  logic   reset_n,
  input  logic   active,
  input  count_t threshold,
  output logic   step
);

  count_t count_q;
  count_t count_d;
  logic   at_limit;

  // Step when the interval is complete; comparing against the live threshold
  // means a lowered threshold fires at once and a raised one stretches the
  // current interval.
  always_comb begin
    at_limit = (threshold <= count_t'(1)) || (count_q >= (threshold - count_t'(1)));
    step     = active && at_limit;
    count_d  = count_q + count_t'(1);
    if (!active || at_limit) begin
      count_d = '0;
    end
  end

  // Cycle counter, cleared asynchronously by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/trajectory.sv
// One axis of the pong ball/paddle position generator. Moves the coordinate
// one unit per step pulse from trajectory_tick. Saturates at 0 and MAX by
// default; define TRAJECTORY_WRAP_EN to wrap modulo 2^(WIDTH+1) instead.
// START must fit in WIDTH+1 bits (upper bits are dropped).
`timescale 1ns/1ps
module trajectory
  import trajectory_pkg::*;
#(
  parameter int          WIDTH = DEFAULT_WIDTH,
  parameter int unsigned START = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  trajectory_if.slave bus
);

  typedef logic [WIDTH:0] coord_w_t;

  localparam coord_w_t COORD_MAX   = '1;
  localparam coord_w_t COORD_START = coord_w_t'(START);

  logic     step;
  coord_w_t coord_q;
  coord_w_t coord_d;

  trajectory_tick u_tick (
    .clock     (clock),
    .reset_n   (reset_n),
    .active    (bus.active),
    .threshold (bus.threshold),
    .step      (step)
  );

  // Next position: one unit in the sampled direction on a step, clamped or
  // wrapped at the ends of the range.
  always_comb begin
    coord_d = coord_q;
    if (step) begin
      if (bus.direction == DIR_UP) begin
`ifdef TRAJECTORY_WRAP_EN
        coord_d = coord_q + coord_w_t'(1);
`else
        if (coord_q != COORD_MAX) begin
          coord_d = coord_q + coord_w_t'(1);
        end
`endif
      end else begin
`ifdef TRAJECTORY_WRAP_EN
        coord_d = coord_q - coord_w_t'(1);
`else
        if (coord_q != '0) begin
          coord_d = coord_q - coord_w_t'(1);
        end
`endif
      end
    end
  end

  // Position register; reset returns to START immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      coord_q <= COORD_START;
    end else begin
      coord_q <= coord_d;
    end
  end

  assign bus.coordinate = coord_q;

endmodule

// File: tb/tb_trajectory.sv
// Bench for trajectory: two axes (START=0 and START=509) checked every cycle
// against a behavioural position model, plus literal checkpoints.
`timescale 1ns/1ps
module tb_trajectory;
  import trajectory_pkg::*;

  localparam int W    = 8;
  localparam int MAXV = (1 << (W + 1)) - 1;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  trajectory_if #(.WIDTH(W)) bus_a ();
  trajectory_if #(.WIDTH(W)) bus_b ();

  trajectory #(.WIDTH(W), .START(0)) dut_a (
    .clock   (clk),
    .reset_n (rst_a),
    .bus     (bus_a.slave)
  );

  trajectory #(.WIDTH(W), .START(509)) dut_b (
    .clock   (clk),
    .reset_n (rst_b),
    .bus     (bus_b.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Position after one unit move in the given direction.
  function automatic int move(input int c, input logic up);
    int n;
    n = up ? c + 1 : c - 1;
`ifdef TRAJECTORY_WRAP_EN
    if (n > MAXV) n = 0;
    if (n < 0) n = MAXV;
`else
    if (n > MAXV) n = MAXV;
    if (n < 0) n = 0;
`endif
    return n;
  endfunction

  // Edges per step: threshold 0 behaves like 1.
  function automatic longint unsigned period(input count_t t);
    return (t == 0) ? 64'd1 : t;
  endfunction

  // Model state: enabled edges seen in the current interval, and position.
  longint unsigned seen_a = 0;
  longint unsigned seen_b = 0;
  int              pos_a  = 0;
  int              pos_b  = 509;

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      seen_a <= 0;
      pos_a  <= 0;
    end else if (!bus_a.active) begin
      seen_a <= 0;
    end else if (seen_a + 1 >= period(bus_a.threshold)) begin
      seen_a <= 0;
      pos_a  <= move(pos_a, bus_a.direction);
    end else begin
      seen_a <= seen_a + 1;
    end
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      seen_b <= 0;
      pos_b  <= 509;
    end else if (!bus_b.active) begin
      seen_b <= 0;
    end else if (seen_b + 1 >= period(bus_b.threshold)) begin
      seen_b <= 0;
      pos_b  <= move(pos_b, bus_b.direction);
    end else begin
      seen_b <= seen_b + 1;
    end
  end

  // Compare both axes against the model shortly after every rising edge.
  always @(posedge clk) begin
    #1;
    check("model_a", 32'(bus_a.coordinate), pos_a);
    check("model_b", 32'(bus_b.coordinate), pos_b);
  end

  // ---------------- stimulus ----------------
  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  int exp_up[5];
  int exp_dn[3];

  initial begin
`ifdef TRAJECTORY_WRAP_EN
    exp_up = '{510, 511, 0, 1, 2};
    exp_dn = '{1, 0, 511};
`else
    exp_up = '{510, 511, 511, 511, 511};
    exp_dn = '{510, 509, 508};
`endif
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.active    = 1'b0;
    bus_a.direction = DIR_UP;
    bus_a.threshold = 64'd50;
    bus_b.active    = 1'b0;
    bus_b.direction = DIR_UP;
    bus_b.threshold = 64'd1;

    edges(3);
    check("reset_a", 32'(bus_a.coordinate), 0);
    check("reset_b", 32'(bus_b.coordinate), 509);
    rst_a = 1'b1;
    rst_b = 1'b1;

    edges(100);
    check("idle_hold", 32'(bus_a.coordinate), 0);

    // Boundary run on axis B, threshold 1: one step per edge.
    bus_b.active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edges(1);
      check($sformatf("b_up_%0d", i), 32'(bus_b.coordinate), exp_up[i]);
    end
    bus_b.direction = DIR_DOWN;
    bus_b.threshold = 64'd0;
    for (int i = 0; i < 3; i++) begin
      edges(1);
      check($sformatf("b_down_%0d", i), 32'(bus_b.coordinate), exp_dn[i]);
    end
    bus_b.active = 1'b0;

    // Axis A: threshold 50 up for 300 edges.
    bus_a.active = 1'b1;
    edges(49);
    check("before_edge50", 32'(bus_a.coordinate), 0);
    edges(1);
    check("step_edge50", 32'(bus_a.coordinate), 1);
    edges(250);
    check("up_300", 32'(bus_a.coordinate), 6);

    bus_a.direction = DIR_DOWN;
    edges(300);
    check("down_300", 32'(bus_a.coordinate), 0);
    bus_a.active = 1'b0;
    edges(20);
    check("frozen_zero", 32'(bus_a.coordinate), 0);

    // Lower threshold mid-count: count 40 of 50, switch to 10.
    bus_a.direction = DIR_UP;
    bus_a.active    = 1'b1;
    edges(40);
    check("count40_hold", 32'(bus_a.coordinate), 0);
    bus_a.threshold = 64'd10;
    edges(1);
    check("lower_thr_next_edge", 32'(bus_a.coordinate), 1);
    edges(9);
    check("thr10_before", 32'(bus_a.coordinate), 1);
    edges(1);
    check("thr10_step", 32'(bus_a.coordinate), 2);

    // Reach coordinate 3 with count 25, then reset asynchronously.
    bus_a.active = 1'b0;
    edges(2);
    bus_a.threshold = 64'd50;
    bus_a.active    = 1'b1;
    edges(50);
    check("pre_reset_pos", 32'(bus_a.coordinate), 3);
    edges(25);
    rst_a = 1'b0;
    #1;
    check("async_reset_now", 32'(bus_a.coordinate), 0);
    edges(3);
    check("reset_held", 32'(bus_a.coordinate), 0);
    rst_a = 1'b1;
    edges(49);
    check("post_reset_49", 32'(bus_a.coordinate), 0);
    edges(1);
    check("post_reset_50", 32'(bus_a.coordinate), 1);

    // Lower boundary on axis A, one step per edge.
    bus_a.direction = DIR_DOWN;
    bus_a.threshold = 64'd1;
    edges(1);
    check("a_down_to_0", 32'(bus_a.coordinate), 0);
    edges(1);
`ifdef TRAJECTORY_WRAP_EN
    check("a_below_0", 32'(bus_a.coordinate), MAXV);
`else
    check("a_below_0", 32'(bus_a.coordinate), 0);
`endif
    bus_a.active = 1'b0;
    edges(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

endmodule
